hdb3_top: RTL and testbench

- Self-contained HDB3 link demonstrator. It has three stages: a repeating NRZ test-pattern source, an HDB3 encoder producing dual-rail polarity outputs, and an HDB3 decoder that turns those rails back into NRZ.
- It is the top level of the FPGA HDB3 demo and is observed directly on a scope or in simulation.

---
 rtl/hdb3_pkg.sv | 15 +
 rtl/hdb3_decoder.sv | 41 ++++
 rtl/hdb3_encoder.sv | 82 ++++++++
 rtl/hdb3_top.sv | 65 ++++++
 tb/tb_hdb3_top.sv | 121 ++++++++++++
 5 files changed

// File: rtl/hdb3_pkg.sv
// Shared symbol encoding and pipeline depth for the HDB3 encoder/decoder pair.
package hdb3_pkg;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_POS  = 2'b10;
    localparam logic [1:0] SYM_NEG  = 2'b01;

    localparam int LATENCY = 4;

    // Dual-rail symbol for a mark of the given polarity (1 = positive).
    function automatic logic [1:0] mark_sym(input logic pos);
        return pos ? SYM_POS : SYM_NEG;
    endfunction

endpackage

// File: rtl/hdb3_decoder.sv
// HDB3 decoder: a V (repeat polarity) cancels itself and the symbol three slots before it.
module hdb3_decoder
    import hdb3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic p_in,
    input  logic n_in,
    output logic dout
);

    // Window = incoming symbol plus three stored ones; line_r[2] is the oldest.
    logic [LATENCY-2:0][1:0] line_r;
    logic                    last_pos_r;
    logic                    mark_s;
    logic                    v_s;

    assign mark_s = p_in | n_in;
    assign v_s    = mark_s && (p_in == last_pos_r);

    // Shift the window and emit the oldest symbol, both V-related slots cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_r     <= {(LATENCY-1){SYM_ZERO}};
            last_pos_r <= 1'b0;
            dout       <= 1'b0;
        end else if (strobe) begin
            dout       <= (|line_r[LATENCY-2]) & ~v_s;
            line_r[2]  <= line_r[1];
            line_r[1]  <= line_r[0];
            line_r[0]  <= v_s ? SYM_ZERO : {p_in, n_in};
            last_pos_r <= mark_s ? p_in : last_pos_r;
        end else begin
            line_r     <= line_r;
            last_pos_r <= last_pos_r;
            dout       <= dout;
        end
    end

endmodule

// File: rtl/hdb3_encoder.sv
// HDB3 encoder: 4-bit lookahead line, AMI marks, B00V/000V substitution of zero runs.
module hdb3_encoder
    import hdb3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic din,
    output logic p,
    output logic n
);

    logic [LATENCY-1:0] bits_r;
    logic [LATENCY-1:0] vmark_r;
    logic [LATENCY-1:0] valid_r;
    logic               last_pos_r;
    logic               odd_r;

    logic               sub_s;
    logic [1:0]         sym_s;
    logic               last_next_s;
    logic               odd_next_s;
    logic [LATENCY-1:0] vmark_next_s;

    // Symbol for the outgoing (oldest) slot; a fresh unmarked all-zero window starts a substitution.
    always_comb begin
        sub_s        = (valid_r == 4'hF) && (bits_r == 4'h0) && (vmark_r == 4'h0);
        sym_s        = SYM_ZERO;
        last_next_s  = last_pos_r;
        odd_next_s   = odd_r;
        vmark_next_s = {vmark_r[LATENCY-2:0], 1'b0};
        if (sub_s) begin
            vmark_next_s = vmark_next_s | 4'b0010;
        end else begin
            vmark_next_s = vmark_next_s;
        end
        if (vmark_r[LATENCY-1]) begin
            sym_s      = mark_sym(last_pos_r);
            odd_next_s = 1'b0;
        end else if (bits_r[LATENCY-1]) begin
            sym_s       = mark_sym(~last_pos_r);
            last_next_s = ~last_pos_r;
            odd_next_s  = ~odd_r;
        end else if (sub_s && !odd_r) begin
            sym_s       = mark_sym(~last_pos_r);
            last_next_s = ~last_pos_r;
            odd_next_s  = ~odd_r;
        end else begin
            sym_s = SYM_ZERO;
        end
    end

    // Pipeline and polarity state advance once per bit strobe; rails are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_r     <= 4'h0;
            vmark_r    <= 4'h0;
            valid_r    <= 4'h0;
            last_pos_r <= 1'b0;
            odd_r      <= 1'b0;
            p          <= 1'b0;
            n          <= 1'b0;
        end else if (strobe) begin
            bits_r     <= {bits_r[LATENCY-2:0], din};
            vmark_r    <= vmark_next_s;
            valid_r    <= {valid_r[LATENCY-2:0], 1'b1};
            last_pos_r <= last_next_s;
            odd_r      <= odd_next_s;
            p          <= sym_s[1];
            n          <= sym_s[0];
        end else begin
            bits_r     <= bits_r;
            vmark_r    <= vmark_r;
            valid_r    <= valid_r;
            last_pos_r <= last_pos_r;
            odd_r      <= odd_r;
            p          <= p;
            n          <= n;
        end
    end

endmodule

// File: rtl/hdb3_top.sv
// HDB3 link demonstrator: repeating NRZ pattern -> HDB3 rails -> recovered NRZ.
module hdb3_top
    import hdb3_pkg::*;
#(
    parameter int          CLK_DIV = 4,
    parameter logic [31:0] PATTERN = 32'hB0C0_0850,
    parameter int          PAT_LEN = 32
) (
    input  logic sys_clk,
    input  logic rst_n,
    output logic data_orig,
    output logic hdb3_p,
    output logic hdb3_n,
    output logic data_decoded
);

    localparam int CW = $clog2(CLK_DIV);

    // rst_n is an active-high synchronous reset despite its name.
    logic          rst;
    logic [CW-1:0] cnt_r;
    logic [4:0]    idx_r;
    logic          strobe_s;
    logic          src_bit_s;

    assign rst       = rst_n;
    assign strobe_s  = (cnt_r == CW'(CLK_DIV - 1));
    assign src_bit_s = PATTERN[5'(PAT_LEN - 1) - idx_r];

    // Bit divider and MSB-first pattern source.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_r     <= '0;
            idx_r     <= 5'd0;
            data_orig <= 1'b0;
        end else if (strobe_s) begin
            cnt_r     <= '0;
            idx_r     <= (idx_r == 5'(PAT_LEN - 1)) ? 5'd0 : idx_r + 5'd1;
            data_orig <= src_bit_s;
        end else begin
            cnt_r     <= cnt_r + CW'(1);
            idx_r     <= idx_r;
            data_orig <= data_orig;
        end
    end

    hdb3_encoder u_enc (
        .clk    (sys_clk),
        .rst    (rst),
        .strobe (strobe_s),
        .din    (src_bit_s),
        .p      (hdb3_p),
        .n      (hdb3_n)
    );

    hdb3_decoder u_dec (
        .clk    (sys_clk),
        .rst    (rst),
        .strobe (strobe_s),
        .p_in   (hdb3_p),
        .n_in   (hdb3_n),
        .dout   (data_decoded)
    );

endmodule

// File: tb/tb_hdb3_top.sv
// Self-checking bench: six parameterisations against a group-based HDB3 reference model.
module tb_hdb3_top;

    localparam int NI = 6;
    localparam int NB = 1024;

    logic           sys_clk = 1'b0;
    logic           rst = 1'b1;
    logic [NI-1:0]  orig_v, p_v, n_v, dec_v;

    int          div_a [NI] = '{4, 4, 4, 4, 4, 2};
    logic [31:0] pat_a [NI] = '{32'hB0C0_0850, 32'hFFFF_FFFF, 32'h0000_0010,
                                32'h0000_0030, 32'h0000_0100, 32'h8000_0001};
    int          len_a [NI] = '{32, 32, 5, 6, 9, 32};

    bit bits_m [NI][NB];
    int sym_m  [NI][NB];
    int disp   [NI];
    int ncyc;
    int n_cmp = 0;
    int n_bad = 0;

    always #10 sys_clk = ~sys_clk;

    hdb3_top #(.CLK_DIV(4), .PATTERN(32'hB0C0_0850), .PAT_LEN(32)) u0 (.sys_clk(sys_clk), .rst_n(rst),
        .data_orig(orig_v[0]), .hdb3_p(p_v[0]), .hdb3_n(n_v[0]), .data_decoded(dec_v[0]));
    hdb3_top #(.CLK_DIV(4), .PATTERN(32'hFFFF_FFFF), .PAT_LEN(32)) u1 (.sys_clk(sys_clk), .rst_n(rst),
        .data_orig(orig_v[1]), .hdb3_p(p_v[1]), .hdb3_n(n_v[1]), .data_decoded(dec_v[1]));
    hdb3_top #(.CLK_DIV(4), .PATTERN(32'h0000_0010), .PAT_LEN(5)) u2 (.sys_clk(sys_clk), .rst_n(rst),
        .data_orig(orig_v[2]), .hdb3_p(p_v[2]), .hdb3_n(n_v[2]), .data_decoded(dec_v[2]));
    hdb3_top #(.CLK_DIV(4), .PATTERN(32'h0000_0030), .PAT_LEN(6)) u3 (.sys_clk(sys_clk), .rst_n(rst),
        .data_orig(orig_v[3]), .hdb3_p(p_v[3]), .hdb3_n(n_v[3]), .data_decoded(dec_v[3]));
    hdb3_top #(.CLK_DIV(4), .PATTERN(32'h0000_0100), .PAT_LEN(9)) u4 (.sys_clk(sys_clk), .rst_n(rst),
        .data_orig(orig_v[4]), .hdb3_p(p_v[4]), .hdb3_n(n_v[4]), .data_decoded(dec_v[4]));
    hdb3_top #(.CLK_DIV(2), .PATTERN(32'h8000_0001), .PAT_LEN(32)) u5 (.sys_clk(sys_clk), .rst_n(rst),
        .data_orig(orig_v[5]), .hdb3_p(p_v[5]), .hdb3_n(n_v[5]), .data_decoded(dec_v[5]));

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", tag, ncyc, obs, exp);
        end
    endtask

    // Textbook HDB3 over the whole bit stream: whole groups of four zeros are replaced at once.
    task automatic build_model();
        for (int i = 0; i < NI; i++) begin
            int last, par, k;
            logic [31:0] pat;
            pat = pat_a[i];
            for (int j = 0; j < NB; j++) begin
                bits_m[i][j] = pat[len_a[i] - 1 - (j % len_a[i])];
                sym_m[i][j]  = 0;
            end
            last = -1; par = 0; k = 0;
            while (k < NB) begin
                if (bits_m[i][k]) begin
                    last = -last; sym_m[i][k] = last; par ^= 1; k++;
                end else if (k + 3 < NB && !bits_m[i][k+1] && !bits_m[i][k+2] && !bits_m[i][k+3]) begin
                    if (par == 0) begin
                        last = -last; sym_m[i][k] = last;
                    end
                    sym_m[i][k+3] = last; par = 0; k += 4;
                end else begin
                    k++;
                end
            end
        end
    endtask

    // Compare every instance against the model for the current strobe count since reset.
    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int s, e_sym, e_pn, e_orig, e_dec;
            s      = ncyc / div_a[i];
            e_orig = (s >= 1) ? int'(bits_m[i][s-1]) : 0;
            e_sym  = (s >= 5) ? sym_m[i][s-5] : 0;
            e_pn   = (e_sym == 1) ? 2 : ((e_sym == -1) ? 1 : 0);
            e_dec  = (s >= 9) ? int'(bits_m[i][s-9]) : 0;
            check_val($sformatf("i%0d data_orig s%0d", i, s), int'(orig_v[i]), e_orig);
            check_val($sformatf("i%0d rails(pn) s%0d", i, s), int'({p_v[i], n_v[i]}), e_pn);
            check_val($sformatf("i%0d data_decoded s%0d", i, s), int'(dec_v[i]), e_dec);
            if (ncyc == 0) begin
                disp[i] = 0;
            end else if (ncyc % div_a[i] == 0) begin
                disp[i] += int'(p_v[i]) - int'(n_v[i]);
                check_val($sformatf("i%0d disparity_in_range", i),
                          int'(disp[i] <= 2 && disp[i] >= -2), 1);
            end
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        if (rst) ncyc = 0;
        else     ncyc++;
        #1;
        check_all();
    endtask

    initial begin
        ncyc = 0;
        build_model();
        for (int c = 0; c < 5; c++) step();
        rst = 1'b0;
        for (int seg = 0; seg < 4; seg++) begin
            int run, hold;
            run  = int'($urandom_range(250, 700));
            hold = (seg == 0) ? 3 : int'($urandom_range(1, 5));
            for (int c = 0; c < run; c++) step();
            rst = 1'b1;
            for (int c = 0; c < hold; c++) step();
            rst = 1'b0;
        end
        for (int c = 0; c < 300; c++) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
